// File: rtl/name_sprite_renderer.sv
// Name-banner sprite renderer: beam -> ROM address, 3-cycle pixel pipeline, typewriter reveal FSM.
// Optional NAME_BLINK_EN: blink the fully revealed banner 16 frames on / 16 frames off in HOLD.
module name_sprite_renderer #(
  parameter int          SPR_W           = 356,
  parameter int          SPR_H           = 12,
  parameter int          POS_X           = 142,
  parameter int          POS_Y           = 100,
  parameter int          REVEAL_STEP     = 4,
  parameter int          FRAMES_PER_STEP = 2,
  parameter logic [7:0]  TRANSPARENT     = 8'h00
) (
  input  logic        i_clk2,
  input  logic        i_rst_n,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  input  logic        i_active,
  input  logic        i_frame_tick,
  input  logic        i_start,
  input  logic        i_clear,
  output logic [12:0] o_rom_addr,
  input  logic [7:0]  i_rom_data,
  output logic [7:0]  o_pixel,
  output logic        o_pixel_valid,
  output logic        o_done
);

  localparam int CW    = $clog2(SPR_W + 1);
  localparam int CW1   = CW + 1;
  localparam int RW    = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int FC_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [9:0]      X_LO      = 10'(POS_X);
  localparam logic [9:0]      X_HI      = 10'(POS_X + SPR_W);
  localparam logic [9:0]      Y_LO      = 10'(POS_Y);
  localparam logic [9:0]      Y_HI      = 10'(POS_Y + SPR_H);
  localparam logic [CW-1:0]   COLS_FULL = CW'(SPR_W);
  localparam logic [CW:0]     STEP      = CW1'(REVEAL_STEP);
  localparam logic [CW:0]     FULL_EXT  = CW1'(SPR_W);
  localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {S_IDLE, S_REVEAL, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   reveal_cols_q, reveal_cols_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [12:0]     rom_addr_q, rom_addr_d;
  logic            shown_d1_q, shown_d1_d;
  logic            shown_d2_q, shown_d2_d;
  logic [7:0]      pixel_q, pixel_d;
  logic            pixel_valid_q, pixel_valid_d;

  logic            in_box, shown, blink_on;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [12:0]     addr;
  logic [CW:0]     step_sum;

`ifdef NAME_BLINK_EN
  logic [4:0] blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (state_d == S_HOLD && state_q != S_HOLD) begin
      blink_d = '0;
    end else if (state_q == S_HOLD && state_d == S_HOLD && i_frame_tick) begin
      blink_d = blink_q + 5'd1;
    end
    blink_on = (state_q != S_HOLD) || !blink_q[4];
  end

  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) blink_q <= '0;
    else          blink_q <= blink_d;
  end
`else
  assign blink_on = 1'b1;
`endif

  // Stage 0: beam position relative to the sprite box.
  always_comb begin
    in_box = i_active && (i_x >= X_LO) && (i_x < X_HI) && (i_y >= Y_LO) && (i_y < Y_HI);
    col    = CW'(i_x - X_LO);
    row    = RW'(i_y - Y_LO);
    addr   = 13'(row) * 13'(SPR_W) + 13'(col);
    shown  = in_box && (col < reveal_cols_q) && blink_on;
  end

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    reveal_cols_d = reveal_cols_q;
    frame_cnt_d   = frame_cnt_q;
    step_sum      = {1'b0, reveal_cols_q} + STEP;
    if (i_clear) begin
      state_d       = S_IDLE;
      reveal_cols_d = '0;
      frame_cnt_d   = '0;
    end else if (i_start) begin
      state_d       = S_REVEAL;
      reveal_cols_d = '0;
      frame_cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          reveal_cols_d = '0;
          frame_cnt_d   = '0;
        end
        S_REVEAL: begin
          if (i_frame_tick) begin
            if (frame_cnt_q == FC_LAST) begin
              frame_cnt_d = '0;
              // Final step overshoots when SPR_W is not a multiple of REVEAL_STEP.
              if (step_sum >= FULL_EXT) begin
                reveal_cols_d = COLS_FULL;
                state_d       = S_HOLD;
              end else begin
                reveal_cols_d = step_sum[CW-1:0];
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          reveal_cols_d = COLS_FULL;
          frame_cnt_d   = '0;
        end
        default: begin
          state_d       = S_IDLE;
          reveal_cols_d = '0;
          frame_cnt_d   = '0;
        end
      endcase
    end
  end

  // Pipeline stages 1..3; the ROM supplies the stage-2 register itself.
  always_comb begin
    rom_addr_d    = in_box ? addr : 13'd0;
    shown_d1_d    = shown;
    shown_d2_d    = shown_d1_q;
    pixel_valid_d = shown_d2_q && (i_rom_data != TRANSPARENT);
    pixel_d       = pixel_valid_d ? i_rom_data : 8'h00;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      reveal_cols_q <= '0;
      frame_cnt_q   <= '0;
      rom_addr_q    <= '0;
      shown_d1_q    <= 1'b0;
      shown_d2_q    <= 1'b0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      reveal_cols_q <= reveal_cols_d;
      frame_cnt_q   <= frame_cnt_d;
      rom_addr_q    <= rom_addr_d;
      shown_d1_q    <= shown_d1_d;
      shown_d2_q    <= shown_d2_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign o_rom_addr    = rom_addr_q;
  assign o_pixel       = pixel_q;
  assign o_pixel_valid = pixel_valid_q;
  assign o_done        = (state_q == S_HOLD);

endmodule

// File: tb/tb_name_sprite_renderer.sv
// Scoreboard bench for name_sprite_renderer: driver queues expected address/pixel, monitor compares.
module tb_name_sprite_renderer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  i_x = '0, i_y = '0;
  logic        i_active = 1'b0, i_frame_tick = 1'b0, i_start = 1'b0, i_clear = 1'b0;
  logic [12:0] o_rom_addr;
  logic [7:0]  rom_data = '0;
  logic [7:0]  o_pixel;
  logic        o_pixel_valid, o_done;

  name_sprite_renderer dut (
    .i_clk2(clk), .i_rst_n(rst_n), .i_x(i_x), .i_y(i_y), .i_active(i_active),
    .i_frame_tick(i_frame_tick), .i_start(i_start), .i_clear(i_clear),
    .o_rom_addr(o_rom_addr), .i_rom_data(rom_data), .o_pixel(o_pixel),
    .o_pixel_valid(o_pixel_valid), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Sprite ROM model: address 0 holds E3, address 5 is see-through, others {1, addr[6:0]}.
  function automatic logic [7:0] rom_of(input logic [12:0] a);
    if (a == 13'd0) return 8'hE3;
    if (a == 13'd5) return 8'h00;
    return {1'b1, a[6:0]};
  endfunction

  always @(posedge clk) rom_data <= rom_of(o_rom_addr);

  typedef struct { int due; logic [12:0] addr; string name; } addr_exp_t;
  typedef struct { int due; logic [7:0] pix; logic vld; string name; } pix_exp_t;

  addr_exp_t addr_q[$];
  pix_exp_t  pix_q[$];
  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every queued expectation on the cycle it falls due.
  initial begin
    forever begin
      @(negedge clk);
      while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
        addr_exp_t e;
        e = addr_q.pop_front();
        check({e.name, "/addr"}, 32'(o_rom_addr), 32'(e.addr));
      end
      while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
        pix_exp_t p;
        p = pix_q.pop_front();
        check({p.name, "/pixel"}, 32'(o_pixel), 32'(p.pix));
        check({p.name, "/valid"}, 32'(o_pixel_valid), 32'(p.vld));
      end
    end
  end

  // Drive one beam position for one cycle and queue its expected responses.
  task automatic vec(input logic [9:0] x, input logic [9:0] y, input logic act,
                     input logic chk_addr, input logic [12:0] ea,
                     input logic [7:0] ep, input logic ev, input string nm);
    addr_exp_t a;
    pix_exp_t  p;
    i_x = x; i_y = y; i_active = act;
    if (chk_addr) begin
      a.due = cyc + 1; a.addr = ea; a.name = nm;
      addr_q.push_back(a);
    end
    p.due = cyc + 3; p.pix = ep; p.vld = ev; p.name = nm;
    pix_q.push_back(p);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_active = 1'b0; i_x = '0; i_y = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input int n);
    i_active = 1'b0;
    repeat (n) begin
      i_frame_tick = 1'b1;
      @(negedge clk);
      i_frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic s, input logic c);
    i_start = s; i_clear = c;
    @(negedge clk);
    i_start = 1'b0; i_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_x = 10'd150; i_y = 10'd105; i_active = 1'b1;
    repeat (2) @(negedge clk);
    check("reset/addr", 32'(o_rom_addr), 0);
    check("reset/pixel", 32'(o_pixel), 0);
    check("reset/valid", 32'(o_pixel_valid), 0);
    check("reset/done", 32'(o_done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE: inside the box but nothing is revealed.
    for (int i = 0; i < 5; i++) vec(10'd150, 10'd105, 1'b1, 1'b0, 13'd0, 8'h00, 1'b0, "idle_no_start");
    idle(4);
    check("idle/done", 32'(o_done), 0);

    // 178 ticks at 2 ticks/step, 4 cols/step: 89 steps reach 356.
    pulse(1'b1, 1'b0);
    tick(177);
    check("tick177/done", 32'(o_done), 0);
    tick(1);
    check("tick178/done", 32'(o_done), 1);

    // HOLD: back-to-back addresses and pixels, box edges, transparency.
    vec(10'd142, 10'd100, 1'b1, 1'b1, 13'd0,    8'hE3, 1'b1, "hold_top_left");
    vec(10'd497, 10'd111, 1'b1, 1'b1, 13'd4271, 8'hAF, 1'b1, "hold_bottom_right");
    vec(10'd143, 10'd101, 1'b1, 1'b1, 13'd357,  8'hE5, 1'b1, "hold_r1c1");
    vec(10'd300, 10'd105, 1'b1, 1'b1, 13'd1938, 8'h92, 1'b1, "hold_r5c158");
    vec(10'd147, 10'd100, 1'b1, 1'b1, 13'd5,    8'h00, 1'b0, "hold_transparent");
    vec(10'd141, 10'd100, 1'b1, 1'b1, 13'd0,    8'h00, 1'b0, "left_of_box");
    vec(10'd498, 10'd100, 1'b1, 1'b1, 13'd0,    8'h00, 1'b0, "right_of_box");
    vec(10'd200, 10'd112, 1'b1, 1'b1, 13'd0,    8'h00, 1'b0, "below_box");
    vec(10'd142, 10'd99,  1'b1, 1'b1, 13'd0,    8'h00, 1'b0, "above_box");
    vec(10'd200, 10'd105, 1'b0, 1'b1, 13'd0,    8'h00, 1'b0, "inactive");
    idle(4);

    // Restart the reveal: 2 ticks uncover cols 0..3.
    pulse(1'b1, 1'b0);
    check("restart/done", 32'(o_done), 0);
    tick(2);
    vec(10'd145, 10'd100, 1'b1, 1'b1, 13'd3, 8'h83, 1'b1, "reveal4_col3");
    vec(10'd146, 10'd100, 1'b1, 1'b1, 13'd4, 8'h00, 1'b0, "reveal4_col4");
    vec(10'd142, 10'd100, 1'b1, 1'b1, 13'd0, 8'hE3, 1'b1, "reveal4_col0");
    idle(4);
    tick(174);
    check("tick176/done", 32'(o_done), 0);
    vec(10'd493, 10'd100, 1'b1, 1'b1, 13'd351, 8'hDF, 1'b1, "reveal352_col351");
    vec(10'd494, 10'd100, 1'b1, 1'b1, 13'd352, 8'h00, 1'b0, "reveal352_col352");
    idle(4);
    tick(2);
    check("tick178b/done", 32'(o_done), 1);
    vec(10'd494, 10'd100, 1'b1, 1'b1, 13'd352, 8'hE0, 1'b1, "full_col352");
    vec(10'd497, 10'd100, 1'b1, 1'b1, 13'd355, 8'hE3, 1'b1, "full_col355");
    idle(4);

`ifdef NAME_BLINK_EN
    tick(15);
    vec(10'd142, 10'd100, 1'b1, 1'b1, 13'd0, 8'hE3, 1'b1, "blink_frame15_on");
    idle(4);
    tick(1);
    check("blink/done_off_phase", 32'(o_done), 1);
    vec(10'd142, 10'd100, 1'b1, 1'b1, 13'd0, 8'h00, 1'b0, "blink_frame16_off");
    idle(4);
    tick(16);
    vec(10'd142, 10'd100, 1'b1, 1'b1, 13'd0, 8'hE3, 1'b1, "blink_frame32_on");
    idle(4);
`endif

    // Clear beats start in the same cycle.
    pulse(1'b1, 1'b1);
    check("start_clear/done", 32'(o_done), 0);
    tick(4);
    vec(10'd142, 10'd100, 1'b1, 1'b1, 13'd0, 8'h00, 1'b0, "start_clear_idle");
    idle(4);

    // Asynchronous reset while REVEAL is drawing an opaque pixel.
    pulse(1'b1, 1'b0);
    tick(10);
    for (int i = 0; i < 4; i++) vec(10'd142, 10'd100, 1'b1, 1'b1, 13'd0, 8'hE3, 1'b1, "pre_reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset/addr", 32'(o_rom_addr), 0);
    check("midreset/pixel", 32'(o_pixel), 0);
    check("midreset/valid", 32'(o_pixel_valid), 0);
    check("midreset/done", 32'(o_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec(10'd142, 10'd100, 1'b1, 1'b1, 13'd0, 8'h00, 1'b0, "post_reset_idle");
    idle(4);
    tick(2);
    check("post_reset/done", 32'(o_done), 0);
    vec(10'd142, 10'd100, 1'b1, 1'b1, 13'd0, 8'h00, 1'b0, "post_reset_ticks");
    idle(4);

    check("scoreboard_drained", 32'(addr_q.size() + pix_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
